sap_controller_sequencer: RTL and testbench
===========================================

Name: sap_controller_sequencer

Overview:
- Controller/sequencer for the 8-bit SAP CPU. It consumes the 4-bit opcode driven by the instruction register and emits the control word that drives the IR (`loadbar`, `output_bar`), PC, MAR, RAM, A, B, ALU and output register.
- A 6-phase one-hot ring counter (T1..T6) steps fetch and execute. HLT parks the machine until reset.

Parameters:
- OP_W, 4, opcode width; must match instruction register width.
- NUM_T, 6, ring length. Only 6 is supported; any other value is an elaboration error.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- opcode_in  input  OP_W  opcode from instruction register upper nibble; always driven, never tristated on this path
- cp  output  1  PC increment (active-high)
- ep  output  1  PC enable onto bus (active-high)
- lm_bar  output  1  MAR load (active-low)
- ce_bar  output  1  RAM enable onto bus (active-low)
- li_bar  output  1  IR load; drives IR `loadbar` (active-low)
- ei_bar  output  1  IR operand onto bus; drives IR `output_bar` (active-low)
- la_bar  output  1  A load (active-low)
- ea  output  1  A onto bus (active-high)
- su  output  1  ALU subtract select (active-high)
- eu  output  1  ALU onto bus (active-high)
- lb_bar  output  1  B load (active-low)
- lo_bar  output  1  output register load (active-low)
- t_state  output  6  one-hot ring state, bit0=T1; all-zero when halted
- halted  output  1  high while in HALT

Behaviour:
- **Clock and reset:**
  - One clock; reset is synchronous and active-high. On a rising clk with rst=1: ring becomes T1, opcode_q becomes 0, HALT clears.
  - While rst=1, every control output is held inactive: active-low lines = 1, active-high lines = 0.
- **Inactive control word (NOP):** cp=ep=ea=su=eu=0; lm_bar=ce_bar=li_bar=ei_bar=la_bar=lb_bar=lo_bar=1.
- **Ring sequencing:** T1->T2->...->T6->T1, one step per clock. From T4 with opcode HLT the next state is HALT, not T5.
- **HALT:**
  - Absorbing state until rst.
  - t_state=0, halted=1, all controls NOP.
  - Mid-instruction reset returns to T1 regardless of phase, including HALT.
- **Control outputs:** combinational decode of (ring state, opcode); valid throughout the cycle for that state. Only lines listed below are active; all others are NOP.
- **Fetch (opcode ignored):**
  - T1: ep=1, lm_bar=0.
  - T2: cp=1.
  - T3: ce_bar=0, li_bar=0. The IR captures on this edge, so opcode_in is valid from T4.
- **Opcode capture:**
  - T4 decodes opcode_in directly.
  - opcode_q samples opcode_in on the T4->T5 edge.
  - T5 and T6 decode opcode_q only, so a change on opcode_in after T4 has no effect.
- **Execute:**
  - LDA 0000:
    - T4: ei_bar=0, lm_bar=0.
    - T5: ce_bar=0, la_bar=0.
    - T6: NOP.
  - ADD 0001:
    - T4: ei_bar=0, lm_bar=0.
    - T5: ce_bar=0, lb_bar=0.
    - T6: eu=1, la_bar=0.
  - SUB 0010: as ADD, except T6: su=1, eu=1, la_bar=0.
  - OUT 1110:
    - T4: ea=1, lo_bar=0.
    - T5, T6: NOP.
  - HLT 1111:
    - T4: NOP; next state HALT.
  - Any other opcode: T4–T6 NOP, no halt.
- **Bus exclusivity invariant:** in every state at most one of {ep, ce_bar==0, ei_bar==0, ea, eu} is asserted.
- **Latency:**
  - Every non-HLT instruction takes exactly 6 clocks.
  - HLT asserts halted in the 5th cycle after fetch start (T1..T4, then HALT).

Decomposition:
- **Shared package (e.g. sap_pkg), holds:**
  - opcode constants OP_LDA/OP_ADD/OP_SUB/OP_OUT/OP_HLT;
  - ring-state one-hot constants T1..T6;
  - control-word field indices and the NOP control-word constant, shared with the datapath top.
- **Sub-module:** one natural sub-module, sap_ring_counter. It holds the one-hot 6-state ring with sync reset, an advance/halt input and the HALT flag.
- **Decode:** stays in sap_controller_sequencer.

Test Plan:
- Reset then run 3 clocks, opcode_in=X → T1 {ep=1,lm_bar=0}, T2 {cp=1}, T3 {ce_bar=0,li_bar=0}; t_state=000001,000010,000100.
- opcode_in=0001 at T4, changed to 1110 at T5 → T4 {ei_bar=0,lm_bar=0}, T5 {ce_bar=0,lb_bar=0}, T6 {eu=1,la_bar=0,su=0}; opcode change ignored; next cycle T1.
- opcode_in=0010 → T6 {su=1,eu=1,la_bar=0}; opcode 1110 → T4 {ea=1,lo_bar=0}, T5/T6 NOP.
- opcode_in=1111 at T4 → next cycle halted=1, t_state=000000, NOP word held for 20 clocks; rst pulse → T1 next edge, halted=0.
- rst=1 asserted during T5 of LDA → outputs NOP while rst high; next edge t_state=000001; fetch restarts cleanly.
- opcode_in=0111 (undefined) → T4–T6 NOP, no halt, returns to T1; bus-exclusivity assertion checked every cycle across all scenarios.

Source files
------------

// File: rtl/sap_controller_sequencer_pkg.sv
// rtl/sap_controller_sequencer_pkg.sv - shared opcodes, ring states and control-word layout for the SAP sequencer
package sap_controller_sequencer_pkg;

  localparam int OPCODE_W = 4;
  localparam int RING_LEN = 6;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

  // HALT is the all-zero ring pattern so t_state reads 0 while parked
  typedef enum logic [RING_LEN-1:0] {
    T_HALT = 6'b000000,
    T1     = 6'b000001,
    T2     = 6'b000010,
    T3     = 6'b000100,
    T4     = 6'b001000,
    T5     = 6'b010000,
    T6     = 6'b100000
  } ring_t;

  localparam int CW_W  = 12;
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

  localparam logic [CW_W-1:0] CW_NOP = 12'b0011_1110_0011;

endpackage

// File: rtl/sap_controller_sequencer_if.sv
// rtl/sap_controller_sequencer_if.sv - opcode input and control-word bundle between sequencer and datapath
interface sap_controller_sequencer_if #(
  parameter int OP_W = 4
);
  logic [OP_W-1:0] opcode_in;
  logic            cp;
  logic            ep;
  logic            lm_bar;
  logic            ce_bar;
  logic            li_bar;
  logic            ei_bar;
  logic            la_bar;
  logic            ea;
  logic            su;
  logic            eu;
  logic            lb_bar;
  logic            lo_bar;
  logic [5:0]      t_state;
  logic            halted;

  modport master (
    input  opcode_in,
    output cp, ep, lm_bar, ce_bar, li_bar, ei_bar, la_bar, ea, su, eu, lb_bar, lo_bar,
    output t_state, halted
  );

  modport slave (
    output opcode_in,
    input  cp, ep, lm_bar, ce_bar, li_bar, ei_bar, la_bar, ea, su, eu, lb_bar, lo_bar,
    input  t_state, halted
  );
endinterface

// File: rtl/sap_controller_sequencer_ring_counter.sv
// rtl/sap_controller_sequencer_ring_counter.sv - one-hot T1..T6 ring with absorbing HALT state
module sap_ring_counter
  import sap_controller_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       halt_req,
  output logic [5:0] t_state,
  output logic       halted
);

  ring_t state_q;
  ring_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      unique case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        T3:      state_d = T4;
        T4:      state_d = halt_req ? T_HALT : T5;
        T5:      state_d = T6;
        T6:      state_d = T1;
        T_HALT:  state_d = T_HALT;
        default: state_d = T1;
      endcase
    end
  end

  assign t_state = state_q;
  assign halted  = (state_q == T_HALT);

endmodule

// File: rtl/sap_controller_sequencer.sv
// rtl/sap_controller_sequencer.sv - SAP fetch/execute sequencer: ring counter plus control-word decode
module sap_controller_sequencer
  import sap_controller_sequencer_pkg::*;
#(
  parameter int OP_W  = OPCODE_W,
  parameter int NUM_T = RING_LEN
) (
  input logic                           clk,
  input logic                           rst,
  sap_controller_sequencer_if.master    bus
);

  generate
    if (NUM_T != RING_LEN || OP_W != OPCODE_W) begin : g_bad_param
      $error("sap_controller_sequencer supports only NUM_T=6 and OP_W=4");
    end
  endgenerate

  logic [5:0]          t_state;
  logic                halted;
  logic                halt_req;
  logic [OPCODE_W-1:0] opcode_q;
  logic [CW_W-1:0]     cw;

  assign halt_req = (t_state == T4) && (bus.opcode_in == OP_HLT);

  sap_ring_counter u_ring (
    .clk      (clk),
    .rst      (rst),
    .advance  (1'b1),
    .halt_req (halt_req),
    .t_state  (t_state),
    .halted   (halted)
  );

  // T5/T6 decode from this copy so opcode_in may move once T4 has passed
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
    end else if (t_state == T4) begin
      opcode_q <= bus.opcode_in;
    end
  end

  always_comb begin
    cw = CW_NOP;
    if (!rst) begin
      unique case (t_state)
        T1: begin
          cw[CW_EP] = 1'b1;
          cw[CW_LM] = 1'b0;
        end
        T2: cw[CW_CP] = 1'b1;
        T3: begin
          cw[CW_CE] = 1'b0;
          cw[CW_LI] = 1'b0;
        end
        T4: begin
          if (bus.opcode_in == OP_LDA || bus.opcode_in == OP_ADD || bus.opcode_in == OP_SUB) begin
            cw[CW_EI] = 1'b0;
            cw[CW_LM] = 1'b0;
          end else if (bus.opcode_in == OP_OUT) begin
            cw[CW_EA] = 1'b1;
            cw[CW_LO] = 1'b0;
          end
        end
        T5: begin
          if (opcode_q == OP_LDA) begin
            cw[CW_CE] = 1'b0;
            cw[CW_LA] = 1'b0;
          end else if (opcode_q == OP_ADD || opcode_q == OP_SUB) begin
            cw[CW_CE] = 1'b0;
            cw[CW_LB] = 1'b0;
          end
        end
        T6: begin
          if (opcode_q == OP_ADD || opcode_q == OP_SUB) begin
            cw[CW_EU] = 1'b1;
            cw[CW_LA] = 1'b0;
            cw[CW_SU] = (opcode_q == OP_SUB);
          end
        end
        default: cw = CW_NOP;
      endcase
    end
  end

  assign bus.cp      = cw[CW_CP];
  assign bus.ep      = cw[CW_EP];
  assign bus.lm_bar  = cw[CW_LM];
  assign bus.ce_bar  = cw[CW_CE];
  assign bus.li_bar  = cw[CW_LI];
  assign bus.ei_bar  = cw[CW_EI];
  assign bus.la_bar  = cw[CW_LA];
  assign bus.ea      = cw[CW_EA];
  assign bus.su      = cw[CW_SU];
  assign bus.eu      = cw[CW_EU];
  assign bus.lb_bar  = cw[CW_LB];
  assign bus.lo_bar  = cw[CW_LO];
  assign bus.t_state = t_state;
  assign bus.halted  = halted;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// tb/tb_sap_controller_sequencer.sv - directed scoreboard bench for the SAP controller/sequencer
module tb_sap_controller_sequencer;

  // {cp,ep,lm_bar,ce_bar,li_bar,ei_bar,la_bar,ea,su,eu,lb_bar,lo_bar}
  localparam logic [11:0] W_NOP  = 12'b0011_1110_0011;
  localparam logic [11:0] W_T1   = 12'b0101_1110_0011;
  localparam logic [11:0] W_T2   = 12'b1011_1110_0011;
  localparam logic [11:0] W_T3   = 12'b0010_0110_0011;
  localparam logic [11:0] W_MEM  = 12'b0001_1010_0011;
  localparam logic [11:0] W_LDA5 = 12'b0010_1100_0011;
  localparam logic [11:0] W_ADD5 = 12'b0010_1110_0001;
  localparam logic [11:0] W_ADD6 = 12'b0011_1100_0111;
  localparam logic [11:0] W_SUB6 = 12'b0011_1100_1111;
  localparam logic [11:0] W_OUT4 = 12'b0011_1111_0010;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;
  localparam logic [5:0] SH = 6'b000000;

  typedef struct {
    string       tag;
    logic [11:0] w;
    logic [5:0]  t;
    logic        h;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  sap_controller_sequencer_if #(.OP_W(4)) bus ();

  sap_controller_sequencer #(.OP_W(4), .NUM_T(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] obs_w;
  assign obs_w = {bus.cp, bus.ep, bus.lm_bar, bus.ce_bar, bus.li_bar, bus.ei_bar,
                  bus.la_bar, bus.ea, bus.su, bus.eu, bus.lb_bar, bus.lo_bar};

  // Drive one clock of stimulus, queue its expectation, check at the falling edge
  task automatic cycle(input string tag, input logic [3:0] op, input logic r,
                       input logic [11:0] w, input logic [5:0] t, input logic h);
    exp_t e;
    int   drivers;
    bus.opcode_in = op;
    rst = r;
    e.tag = tag; e.w = w; e.t = t; e.h = h;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (obs_w === e.w) else begin
      failures++;
      $error("FAIL %s ctrl observed=%b expected=%b", e.tag, obs_w, e.w);
    end
    checks++;
    assert (bus.t_state === e.t) else begin
      failures++;
      $error("FAIL %s t_state observed=%b expected=%b", e.tag, bus.t_state, e.t);
    end
    checks++;
    assert (bus.halted === e.h) else begin
      failures++;
      $error("FAIL %s halted observed=%b expected=%b", e.tag, bus.halted, e.h);
    end
    drivers = $countones({bus.ep, ~bus.ce_bar, ~bus.ei_bar, bus.ea, bus.eu});
    checks++;
    assert (drivers <= 1) else begin
      failures++;
      $error("FAIL %s bus_excl observed=%0d expected<=1", e.tag, drivers);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    cycle({tag, "_t1"}, 4'bxxxx, 1'b0, W_T1, S1, 1'b0);
    cycle({tag, "_t2"}, 4'bxxxx, 1'b0, W_T2, S2, 1'b0);
    cycle({tag, "_t3"}, 4'bxxxx, 1'b0, W_T3, S3, 1'b0);
  endtask

  initial begin
    bus.opcode_in = 4'b0000;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cycle("reset", 4'b0000, 1'b1, W_NOP, S1, 1'b0);

    fetch("add");
    cycle("add_t4", 4'b0001, 1'b0, W_MEM,  S4, 1'b0);
    cycle("add_t5", 4'b1110, 1'b0, W_ADD5, S5, 1'b0);
    cycle("add_t6", 4'b1110, 1'b0, W_ADD6, S6, 1'b0);

    fetch("sub");
    cycle("sub_t4", 4'b0010, 1'b0, W_MEM,  S4, 1'b0);
    cycle("sub_t5", 4'b0010, 1'b0, W_ADD5, S5, 1'b0);
    cycle("sub_t6", 4'b0010, 1'b0, W_SUB6, S6, 1'b0);

    fetch("out");
    cycle("out_t4", 4'b1110, 1'b0, W_OUT4, S4, 1'b0);
    cycle("out_t5", 4'b1110, 1'b0, W_NOP,  S5, 1'b0);
    cycle("out_t6", 4'b1110, 1'b0, W_NOP,  S6, 1'b0);

    fetch("lda_rst");
    cycle("lda_rst_t4", 4'b0000, 1'b0, W_MEM, S4, 1'b0);
    cycle("lda_rst_t5", 4'b0000, 1'b1, W_NOP, S5, 1'b0);

    fetch("lda");
    cycle("lda_t4", 4'b0000, 1'b0, W_MEM,  S4, 1'b0);
    cycle("lda_t5", 4'b0001, 1'b0, W_LDA5, S5, 1'b0);
    cycle("lda_t6", 4'b0001, 1'b0, W_NOP,  S6, 1'b0);

    fetch("undef");
    cycle("undef_t4", 4'b0111, 1'b0, W_NOP, S4, 1'b0);
    cycle("undef_t5", 4'b0111, 1'b0, W_NOP, S5, 1'b0);
    cycle("undef_t6", 4'b0111, 1'b0, W_NOP, S6, 1'b0);

    fetch("hlt");
    cycle("hlt_t4", 4'b1111, 1'b0, W_NOP, S4, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle("hlt_park", (i % 2 == 0) ? 4'b0001 : 4'b1110, 1'b0, W_NOP, SH, 1'b1);
    end
    cycle("hlt_rst", 4'b0000, 1'b1, W_NOP, SH, 1'b1);
    fetch("post_hlt");
    cycle("post_hlt_t4", 4'b0001, 1'b0, W_MEM, S4, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
